// File: rtl/id_issue_buf.sv
// Decode-to-execute issue buffer: 2-entry skid buffer with capture-time operand
// bypass resolution, load-use hazard interlock, flush and a bubble counter.
module id_issue_buf #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int CTRL_W  = 32,
  parameter int NUM_BYP = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [CTRL_W-1:0]           in_ctrl_i,
  input  logic [ADDR_W-1:0]           in_rs1_addr_i,
  input  logic [ADDR_W-1:0]           in_rs2_addr_i,
  input  logic [DATA_W-1:0]           in_rs1_data_i,
  input  logic [DATA_W-1:0]           in_rs2_data_i,
  input  logic [ADDR_W-1:0]           in_rd_addr_i,
  input  logic                        in_rd_wr_en_i,
  input  logic                        in_is_load_i,
  input  logic [NUM_BYP-1:0]          byp_valid_i,
  input  logic [NUM_BYP*ADDR_W-1:0]   byp_addr_i,
  input  logic [NUM_BYP*DATA_W-1:0]   byp_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [CTRL_W-1:0]           out_ctrl_o,
  output logic [DATA_W-1:0]           out_rs1_data_o,
  output logic [DATA_W-1:0]           out_rs2_data_o,
  output logic [ADDR_W-1:0]           out_rd_addr_o,
  output logic                        out_rd_wr_en_o,
  output logic                        out_is_load_o,
  output logic                        load_use_stall_o,
  output logic [15:0]                 bubble_cnt_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_wr_en;
    logic              is_load;
  } entry_t;

  entry_t            e0_q, e1_q, new_entry;
  logic [1:0]        count_q;
  logic              fired_vld_q;
  logic [ADDR_W-1:0] fired_rd_q;
  logic [15:0]       bubble_cnt_q;

  logic in_fire, out_fire, hazard;
  logic e0_load, e1_load, rs1_hit, rs2_hit;

  // Lowest-index matching channel wins, so scan from the top and let later
  // (younger) matches overwrite; register x0 always reads as zero.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0]         addr,
    input logic [DATA_W-1:0]         rf_data,
    input logic [NUM_BYP-1:0]        bv,
    input logic [NUM_BYP*ADDR_W-1:0] ba,
    input logic [NUM_BYP*DATA_W-1:0] bd
  );
    logic [DATA_W-1:0] r;
    r = rf_data;
    for (int k = NUM_BYP - 1; k >= 0; k--) begin
      if (bv[k] && (ba[k*ADDR_W +: ADDR_W] == addr)) r = bd[k*DATA_W +: DATA_W];
    end
    if (addr == '0) r = '0;
    return r;
  endfunction

  always_comb begin
    new_entry          = '0;
    new_entry.ctrl     = in_ctrl_i;
    new_entry.rs1_data = resolve(in_rs1_addr_i, in_rs1_data_i, byp_valid_i, byp_addr_i, byp_data_i);
    new_entry.rs2_data = resolve(in_rs2_addr_i, in_rs2_data_i, byp_valid_i, byp_addr_i, byp_data_i);
    new_entry.rd_addr  = in_rd_addr_i;
    new_entry.rd_wr_en = in_rd_wr_en_i;
    new_entry.is_load  = in_is_load_i;
  end

  // A buffered load only blocks consumers once it is known to write a real register.
  assign e0_load = (count_q != 2'd0) & e0_q.is_load & e0_q.rd_wr_en & (e0_q.rd_addr != '0);
  assign e1_load = (count_q == 2'd2) & e1_q.is_load & e1_q.rd_wr_en & (e1_q.rd_addr != '0);

  assign rs1_hit = (in_rs1_addr_i != '0) &
                   ((e0_load & (e0_q.rd_addr == in_rs1_addr_i)) |
                    (e1_load & (e1_q.rd_addr == in_rs1_addr_i)) |
                    (fired_vld_q & (fired_rd_q == in_rs1_addr_i)));
  assign rs2_hit = (in_rs2_addr_i != '0) &
                   ((e0_load & (e0_q.rd_addr == in_rs2_addr_i)) |
                    (e1_load & (e1_q.rd_addr == in_rs2_addr_i)) |
                    (fired_vld_q & (fired_rd_q == in_rs2_addr_i)));

  assign hazard      = in_valid_i & (rs1_hit | rs2_hit);
  assign out_valid_o = (count_q != 2'd0);
  assign out_fire    = out_valid_o & out_ready_i;
  assign in_ready_o  = ((count_q != 2'd2) | out_fire) & ~hazard & ~flush_i;
  assign in_fire     = in_valid_i & in_ready_o;

  // NOTE: the entry storage is only two registers wide, so it is reset along with
  // the control state; that keeps out_* at zero after reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q         <= '0;
      e1_q         <= '0;
      count_q      <= 2'd0;
      fired_vld_q  <= 1'b0;
      fired_rd_q   <= '0;
      bubble_cnt_q <= 16'd0;
    end else begin
      if (hazard && !flush_i && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_q <= bubble_cnt_q + 16'd1;

      // The load result reaches a bypass channel one cycle after it leaves for EX.
      fired_vld_q <= ~flush_i & out_fire & e0_load;
      fired_rd_q  <= e0_q.rd_addr;

      if (flush_i) begin
        count_q <= 2'd0;
      end else if (in_fire && out_fire) begin
        if (count_q == 2'd2) begin
          e0_q <= e1_q;
          e1_q <= new_entry;
        end else begin
          e0_q <= new_entry;
        end
      end else if (in_fire) begin
        if (count_q == 2'd0) e0_q <= new_entry;
        else                 e1_q <= new_entry;
        count_q <= count_q + 2'd1;
      end else if (out_fire) begin
        e0_q    <= e1_q;
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign out_ctrl_o       = e0_q.ctrl;
  assign out_rs1_data_o   = e0_q.rs1_data;
  assign out_rs2_data_o   = e0_q.rs2_data;
  assign out_rd_addr_o    = e0_q.rd_addr;
  assign out_rd_wr_en_o   = e0_q.rd_wr_en;
  assign out_is_load_o    = e0_q.is_load;
  assign load_use_stall_o = hazard;
  assign bubble_cnt_o     = bubble_cnt_q;

endmodule

// File: tb/tb_id_issue_buf.sv
// Self-checking bench for id_issue_buf: bypass vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_id_issue_buf;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int CTRL_W  = 32;
  localparam int NUM_BYP = 3;

  logic                      clk, rst_n, flush_i;
  logic                      in_valid_i, in_ready_o;
  logic [CTRL_W-1:0]         in_ctrl_i;
  logic [ADDR_W-1:0]         in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i;
  logic [DATA_W-1:0]         in_rs1_data_i, in_rs2_data_i;
  logic                      in_rd_wr_en_i, in_is_load_i;
  logic [NUM_BYP-1:0]        byp_valid_i;
  logic [NUM_BYP*ADDR_W-1:0] byp_addr_i;
  logic [NUM_BYP*DATA_W-1:0] byp_data_i;
  logic                      out_valid_o, out_ready_i;
  logic [CTRL_W-1:0]         out_ctrl_o;
  logic [DATA_W-1:0]         out_rs1_data_o, out_rs2_data_o;
  logic [ADDR_W-1:0]         out_rd_addr_o;
  logic                      out_rd_wr_en_o, out_is_load_o, load_use_stall_o;
  logic [15:0]               bubble_cnt_o;

  id_issue_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NUM_BYP(NUM_BYP)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_ctrl_i(in_ctrl_i),
    .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i),
    .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
    .in_rd_addr_i(in_rd_addr_i), .in_rd_wr_en_i(in_rd_wr_en_i), .in_is_load_i(in_is_load_i),
    .byp_valid_i(byp_valid_i), .byp_addr_i(byp_addr_i), .byp_data_i(byp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ctrl_o(out_ctrl_o),
    .out_rs1_data_o(out_rs1_data_o), .out_rs2_data_o(out_rs2_data_o),
    .out_rd_addr_o(out_rd_addr_o), .out_rd_wr_en_o(out_rd_wr_en_o),
    .out_is_load_o(out_is_load_o), .load_use_stall_o(load_use_stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rs1, rs2;
    logic [ADDR_W-1:0] rd;
    bit                wr, ld;
  } ent_t;

  ent_t              m_q[$];
  bit                m_fired_v;
  logic [ADDR_W-1:0] m_fired_rd;
  int                m_bubble;

  function automatic logic [DATA_W-1:0] m_resolve(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] rf);
    if (a == 0) return '0;
    for (int k = 0; k < NUM_BYP; k++)
      if (byp_valid_i[k] && byp_addr_i[k*ADDR_W +: ADDR_W] == a) return byp_data_i[k*DATA_W +: DATA_W];
    return rf;
  endfunction

  function automatic bit m_blocks(input logic [ADDR_W-1:0] src);
    if (src == 0) return 0;
    foreach (m_q[i])
      if (m_q[i].ld && m_q[i].wr && m_q[i].rd != 0 && m_q[i].rd == src) return 1;
    return m_fired_v && (m_fired_rd == src);
  endfunction

  function automatic bit m_hazard();
    return in_valid_i && (m_blocks(in_rs1_addr_i) || m_blocks(in_rs2_addr_i));
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_fired_v  = 0;
    m_fired_rd = '0;
    m_bubble   = 0;
  endtask

  // Compare every observable against the model, advance the model by one clock,
  // and return at the next falling edge.
  task automatic tick();
    bit haz, rdy, of, inf, nf;
    logic [ADDR_W-1:0] nrd;
    ent_t e;
    #1;
    haz = m_hazard();
    rdy = (m_q.size() < 2 || (m_q.size() > 0 && out_ready_i)) && !haz && !flush_i;
    check("in_ready", in_ready_o, rdy);
    check("stall", load_use_stall_o, haz);
    check("out_valid", out_valid_o, m_q.size() > 0);
    check("bubble_cnt", bubble_cnt_o, m_bubble);
    if (m_q.size() > 0) begin
      check("out_ctrl", out_ctrl_o, m_q[0].ctrl);
      check("out_rs1", out_rs1_data_o, m_q[0].rs1);
      check("out_rs2", out_rs2_data_o, m_q[0].rs2);
      check("out_rd", out_rd_addr_o, m_q[0].rd);
      check("out_flags", {out_rd_wr_en_o, out_is_load_o}, {m_q[0].wr, m_q[0].ld});
    end
    of  = (m_q.size() > 0) && out_ready_i;
    inf = in_valid_i && rdy;
    nf  = 0;
    nrd = '0;
    if (of) begin
      nf  = !flush_i && m_q[0].ld && m_q[0].wr && m_q[0].rd != 0;
      nrd = m_q[0].rd;
    end
    if (haz && !flush_i && m_bubble < 65535) m_bubble++;
    if (of) void'(m_q.pop_front());
    if (inf) begin
      e.ctrl = in_ctrl_i;
      e.rs1  = m_resolve(in_rs1_addr_i, in_rs1_data_i);
      e.rs2  = m_resolve(in_rs2_addr_i, in_rs2_data_i);
      e.rd   = in_rd_addr_i;
      e.wr   = in_rd_wr_en_i;
      e.ld   = in_is_load_i;
      m_q.push_back(e);
    end
    if (flush_i) m_q.delete();
    m_fired_v  = nf;
    m_fired_rd = nrd;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid_i = 0; flush_i = 0; in_ctrl_i = '0;
    in_rs1_addr_i = '0; in_rs2_addr_i = '0; in_rd_addr_i = '0;
    in_rs1_data_i = '0; in_rs2_data_i = '0;
    in_rd_wr_en_i = 0; in_is_load_i = 0;
    byp_valid_i = '0; byp_addr_i = '0; byp_data_i = '0;
  endtask

  task automatic instr(input logic [CTRL_W-1:0] c, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                       input logic [ADDR_W-1:0] rd, input bit ld);
    in_valid_i = 1; in_ctrl_i = c;
    in_rs1_addr_i = r1; in_rs2_addr_i = r2; in_rd_addr_i = rd;
    in_rs1_data_i = 64'h1000 + r1; in_rs2_data_i = 64'h2000 + r2;
    in_rd_wr_en_i = 1; in_is_load_i = ld;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] rs1;
    logic [2:0]        bv;
    logic [ADDR_W-1:0] a0, a1, a2;
    logic [DATA_W-1:0] d0, d1, d2, rf, exp;
  } byp_vec_t;

  byp_vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    int stalls, bub0;
    bit accepted;
    logic [CTRL_W-1:0] got[$];

    vecs[0] = '{5'd5, 3'b110, 5'd5, 5'd5, 5'd5, 64'h11, 64'hAA, 64'hBB, 64'hCC, 64'hAA};
    vecs[1] = '{5'd5, 3'b000, 5'd5, 5'd5, 5'd5, 64'h11, 64'hAA, 64'hBB, 64'hCC, 64'hCC};
    vecs[2] = '{5'd0, 3'b111, 5'd0, 5'd0, 5'd0, 64'h11, 64'hAA, 64'hBB, 64'hCC, 64'h0};
    vecs[3] = '{5'd5, 3'b111, 5'd5, 5'd5, 5'd5, 64'h11, 64'hAA, 64'hBB, 64'hCC, 64'h11};
    vecs[4] = '{5'd5, 3'b111, 5'd3, 5'd4, 5'd5, 64'h11, 64'hAA, 64'hBB, 64'hCC, 64'hBB};
    vecs[5] = '{5'd5, 3'b011, 5'd3, 5'd4, 5'd5, 64'h11, 64'hAA, 64'hBB, 64'hCC, 64'hCC};

    idle();
    out_ready_i = 0;
    rst_n = 0;
    m_reset();
    #12;
    check("reset_out_valid", out_valid_o, 0);
    check("reset_out_data", {out_ctrl_o, out_rs1_data_o, out_rd_addr_o}, '0);
    check("reset_in_ready", in_ready_o, 1);
    @(negedge clk);
    rst_n = 1;
    out_ready_i = 1;

    // Bypass priority table.
    foreach (vecs[i]) begin
      instr(32'h10 + i, vecs[i].rs1, 5'd0, 5'd1, 0);
      in_rs1_data_i = vecs[i].rf;
      byp_valid_i = vecs[i].bv;
      byp_addr_i  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      byp_data_i  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      tick();
      idle();
      check($sformatf("byp_vec%0d", i), out_rs1_data_o, vecs[i].exp);
      tick();
    end

    // Back-to-back independent ops, one per cycle, one-cycle latency.
    for (int i = 1; i <= 4; i++) begin
      instr(i, 5'd1, 5'd2, 5'd3, 0);
      tick();
      check("b2b_valid", out_valid_o, 1);
      check("b2b_ctrl", out_ctrl_o, i);
    end
    idle();
    tick();
    check("b2b_bubbles", bubble_cnt_o, 0);

    // Load-use: the dependent add waits until ch0 carries the load result.
    instr(32'h50, 5'd1, 5'd2, 5'd7, 1);
    tick();
    instr(32'h51, 5'd3, 5'd7, 5'd8, 0);
    byp_valid_i = 3'b001; byp_addr_i = {10'd0, 5'd7}; byp_data_i = {128'd0, 64'h77};
    bub0 = bubble_cnt_o;
    stalls = 0;
    accepted = 0;
    for (int c = 0; c < 10 && !accepted; c++) begin
      #1;
      if (in_ready_o) accepted = 1; else stalls++;
      tick();
    end
    check("lu_accepted", accepted, 1);
    check("lu_stall_cycles", stalls, 2);
    check("lu_bubbles", bubble_cnt_o - bub0, 2);
    idle();
    check("lu_bypassed_rs2", out_rs2_data_o, 64'h77);
    tick();

    // Backpressure: two absorbed, third refused, order preserved after release.
    out_ready_i = 0;
    for (int i = 1; i <= 3; i++) begin
      instr(32'h100 + i, 5'd1, 5'd2, 5'd3, 0);
      #1;
      check($sformatf("bp_ready%0d", i), in_ready_o, i < 3);
      tick();
    end
    out_ready_i = 1;
    #1;
    check("bp_ready_release", in_ready_o, 1);
    for (int c = 0; c < 6; c++) begin
      if (out_valid_o) got.push_back(out_ctrl_o);
      if (in_valid_i && in_ready_o) begin
        tick();
        idle();
      end else begin
        tick();
      end
    end
    check("bp_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("bp_order", got[i], 32'h101 + i);

    // Flush with a full buffer, a pending load hazard and an incoming instruction.
    out_ready_i = 0;
    instr(32'h201, 5'd1, 5'd2, 5'd9, 1);
    tick();
    instr(32'h202, 5'd1, 5'd2, 5'd4, 0);
    tick();
    instr(32'h2FF, 5'd9, 5'd0, 5'd5, 0);
    #1;
    check("fl_pre_stall", load_use_stall_o, 1);
    flush_i = 1;
    tick();
    flush_i = 0;
    instr(32'h203, 5'd9, 5'd0, 5'd5, 0);
    #1;
    check("fl_out_valid", out_valid_o, 0);
    check("fl_stall_cleared", load_use_stall_o, 0);
    tick();
    idle();
    out_ready_i = 1;
    check("fl_next_head", out_ctrl_o, 32'h203);
    tick();

    // Asynchronous reset between clock edges while entries are buffered.
    out_ready_i = 0;
    instr(32'h301, 5'd1, 5'd2, 5'd3, 0);
    tick();
    instr(32'h302, 5'd1, 5'd2, 5'd3, 0);
    tick();
    #2;
    rst_n = 0;
    idle();
    #1;
    check("ar_out_valid", out_valid_o, 0);
    check("ar_out_data", {out_ctrl_o, out_rs2_data_o, out_rd_wr_en_o, out_is_load_o}, '0);
    check("ar_bubble", bubble_cnt_o, 0);
    check("ar_in_ready", in_ready_o, 1);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    out_ready_i = 1;
    instr(32'h310, 5'd1, 5'd2, 5'd3, 0);
    tick();
    idle();
    check("ar_first_latency", {out_valid_o, out_ctrl_o}, {1'b1, 32'h310});
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid_i    = ($urandom_range(0, 3) != 0);
      in_ctrl_i     = $urandom;
      in_rs1_addr_i = $urandom_range(0, 7);
      in_rs2_addr_i = $urandom_range(0, 7);
      in_rd_addr_i  = $urandom_range(0, 7);
      in_rs1_data_i = {$urandom, $urandom};
      in_rs2_data_i = {$urandom, $urandom};
      in_rd_wr_en_i = ($urandom_range(0, 5) != 0);
      in_is_load_i  = ($urandom_range(0, 3) == 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      out_ready_i   = ($urandom_range(0, 3) != 0);
      byp_valid_i   = $urandom_range(0, 7);
      for (int k = 0; k < NUM_BYP; k++) begin
        byp_addr_i[k*ADDR_W +: ADDR_W] = $urandom_range(0, 7);
        byp_data_i[k*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_issue_buf.md
# id_issue_buf

Parametrised decode-to-execute issue buffer replacing the fixed ID/EX pipeline register. It sits between the decoder and the EX stage and captures decoded instructions through a 2-entry skid buffer with valid/ready handshakes on both sides. On capture it resolves operands from NUM_BYP prioritised bypass channels, detects load-use hazards and refuses the consumer until the load data can be bypassed. It flushes on a taken jump and counts hazard bubbles.

## Interface
- DATA_W, 64, operand/register data width
- ADDR_W, 5, register address width
- CTRL_W, 32, width of the packed decoded control bundle (ALU op, add/sub, shift, load/store codes), carried opaquely
- NUM_BYP, 3, number of bypass channels; channel 0 is the youngest and has the highest priority
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  taken jump/branch; kill all buffered and incoming work
- in_valid_i  in  1  decoder presents an instruction
- in_ready_o  out  1  buffer accepts this cycle
- in_ctrl_i  in  CTRL_W  decoded control bundle
- in_rs1_addr_i, in_rs2_addr_i  in  ADDR_W  source register addresses
- in_rs1_data_i, in_rs2_data_i  in  DATA_W  register-file read data
- in_rd_addr_i  in  ADDR_W  destination address
- in_rd_wr_en_i  in  1  destination write enable
- in_is_load_i  in  1  instruction is a load
- byp_valid_i  in  NUM_BYP  bypass channel valid
- byp_addr_i  in  NUM_BYP*ADDR_W  bypass destination addresses, channel k at [k*ADDR_W +: ADDR_W]
- byp_data_i  in  NUM_BYP*DATA_W  bypass data, same packing
- out_valid_o  out  1  head entry valid to EX
- out_ready_i  in  1  EX accepts head
- out_ctrl_o  out  CTRL_W  head control bundle
- out_rs1_data_o, out_rs2_data_o  out  DATA_W  head resolved operands
- out_rd_addr_o  out  ADDR_W  head destination
- out_rd_wr_en_o, out_is_load_o  out  1  head flags
- load_use_stall_o  out  1  hazard is blocking the input this cycle
- bubble_cnt_o  out  16  saturating count of hazard-stalled cycles

## Operation
- Storage: entries E0 (head) and E1 (tail), plus a count register (0..2). Outputs are driven directly from the E0 registers.
- Fires: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o = (count<2 | out_fire) & !hazard & !flush_i.
- Operand resolution happens at capture, per source. If the address is 0, the operand is 0. Otherwise the lowest-index channel k with byp_valid_i[k] and byp_addr==addr supplies the data. If no channel matches, the register-file data is used.
- Hazard is asserted when in_valid_i is high and any in_rs1/rs2 address (≠0) equals the rd of any of these:
  - a valid buffered entry with is_load & rd_wr_en & rd≠0;
  - fired_load_q: a one-cycle register set on the out_fire of such a load entry, holding its rd.
- The hazard clears automatically the cycle after fired_load_q drops, when the load result is on a bypass channel.
- load_use_stall_o = hazard.
- bubble_cnt_o increments on each cycle with hazard & !flush_i and saturates at 16'hFFFF. Flush does not clear it.
- Simultaneous in_fire and out_fire:
  - E1 shifts to E0 and the new instruction goes to E1.
  - If E1 was empty, the new instruction goes to E0.
  - Count is unchanged.
- flush_i has top priority:
  - next cycle count=0 and fired_load_q=0;
  - an out_fire in the same cycle is still a valid transfer to EX;
  - in_valid_i in the flush cycle is dropped.

## Timing
- Reset (async): count=0, out_valid_o=0, all out_* data/ctrl=0, fired_load_q=0, bubble_cnt_o=0, in_ready_o=1 (when in_valid_i=0).
- Latency: an instruction captured in cycle t is on out_* in cycle t+1 when the buffer is empty.
- Throughput: 1 instruction/cycle with out_ready_i held high.
- Backpressure: with out_ready_i low, two instructions are absorbed, then in_ready_o drops. It rises again combinationally in the cycle out_ready_i returns.
- Dependent instruction directly after a load costs ≥2 bubble cycles: the load is buffered, then fired_load_q is high.
- A reset during a handshake discards all entries immediately.

## Test plan
- Back-to-back independent ops, out_ready_i=1: 4 instructions in 4 cycles appear on out_* at cycles 1..4; bubble_cnt_o=0.
- Bypass priority: rs1=5, byp_valid=3'b110, ch1 data=0xAA, ch2 data=0xBB, regfile=0xCC -> out_rs1_data_o=0xAA. With byp_valid=3'b000 -> 0xCC. With rs1=0 -> 0.
- Load-use: load rd=7, then add rs2=7 with out_ready_i=1:
  - in_ready_o low for exactly 2 cycles;
  - load_use_stall_o high for those cycles;
  - bubble_cnt_o=2;
  - the add is accepted when ch0 supplies x7.
- Backpressure: out_ready_i=0 with 3 valid inputs:
  - inputs 1 and 2 are accepted, in_ready_o=0 for input 3;
  - after release, order 1,2,3 is preserved with no loss or duplication.
- Flush with count=2 and in_valid_i=1: next cycle out_valid_o=0 and count=0, the incoming instruction never appears, and a pending load hazard is cleared.
- Async reset asserted mid-stream between clock edges: all outputs reach reset values without a clock edge. The first instruction after release appears 1 cycle after acceptance.
